// File: rtl/vga_mem_arbiter.sv
// Arbitrates a single-port character memory between the VGA fetch path and a host port.
// Video reads take every 8th active pixel; the host is served in all other cycles.
module vga_mem_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int BLANK_ONLY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              display_on,
    input  logic [9:0]        hpos,
    input  logic [9:0]        vpos,
    input  logic              vsync,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic [7:0]        frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VID_RD  = 2'd1,
        ST_HOST_RD = 2'd2
    } state_t;

    state_t              state_r;
    logic                host_gnt_r;
    logic                host_rvalid_r;
    logic [DATA_W-1:0]   host_rdata_r;
    logic                mem_en_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   vid_data_r;
    logic                vid_valid_r;
    logic [7:0]          frame_cnt_r;
    logic                vsync_r;

    logic                vid_slot_s;
    logic                host_ok_s;
    logic                grant_s;
    logic [ADDR_W-1:0]   vid_addr_s;
    logic                unused_pos_s;

    // Slot detection, host eligibility and the 80-column cell address.
    always_comb begin
        vid_slot_s   = display_on & (hpos[2:0] == 3'd0);
        host_ok_s    = (BLANK_ONLY != 0) ? ~display_on : 1'b1;
        grant_s      = host_req & ~vid_slot_s & host_ok_s;
        vid_addr_s   = ADDR_W'({8'd0, vpos[8:3]} * 14'd80 + {7'd0, hpos[9:3]});
        unused_pos_s = ^{vpos[9], vpos[2:0]};
    end

    // Arbitration FSM: issues one memory access per cycle and captures read data
    // at the end of the cycle following the strobe (mem_rdata valid by then).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            host_gnt_r    <= 1'b0;
            host_rvalid_r <= 1'b0;
            host_rdata_r  <= {DATA_W{1'b0}};
            mem_en_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_wdata_r   <= {DATA_W{1'b0}};
            vid_data_r    <= {DATA_W{1'b0}};
            vid_valid_r   <= 1'b0;
        end else begin
            host_gnt_r    <= 1'b0;
            host_rvalid_r <= 1'b0;
            vid_valid_r   <= 1'b0;
            mem_en_r      <= 1'b0;
            mem_we_r      <= 1'b0;

            case (state_r)
                ST_VID_RD: begin
                    vid_data_r  <= mem_rdata;
                    vid_valid_r <= 1'b1;
                end
                ST_HOST_RD: begin
                    host_rdata_r  <= mem_rdata;
                    host_rvalid_r <= 1'b1;
                end
                ST_IDLE: begin
                end
                default: begin
                end
            endcase

            // Video wins the slot outright; host is served otherwise.
            if (vid_slot_s) begin
                mem_en_r   <= 1'b1;
                mem_addr_r <= vid_addr_s;
                state_r    <= ST_VID_RD;
            end else if (grant_s) begin
                host_gnt_r <= 1'b1;
                mem_en_r   <= 1'b1;
                mem_we_r   <= host_we;
                mem_addr_r <= host_addr;
                if (host_we) begin
                    mem_wdata_r <= host_wdata;
                    state_r     <= ST_IDLE;
                end else begin
                    state_r     <= ST_HOST_RD;
                end
            end else begin
                state_r <= ST_IDLE;
            end
        end
    end

    // Frame counter on registered vsync rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_r     <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            vsync_r <= vsync;
            if (vsync & ~vsync_r) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign host_gnt    = host_gnt_r;
    assign host_rvalid = host_rvalid_r;
    assign host_rdata  = host_rdata_r;
    assign mem_en      = mem_en_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign vid_data    = vid_data_r;
    assign vid_valid   = vid_valid_r;
    assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter: one default instance with a memory model
// and one BLANK_ONLY instance that shares the stimulus.
module tb_vga_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        display_on = 1'b0;
    logic [9:0]  hpos = 10'd0;
    logic [9:0]  vpos = 10'd0;
    logic        vsync = 1'b0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [12:0] host_addr = 13'd0;
    logic [7:0]  host_wdata = 8'd0;

    logic        host_gnt, host_rvalid, mem_en, mem_we, vid_valid;
    logic [7:0]  host_rdata, mem_wdata, mem_rdata, vid_data, frame_cnt;
    logic [12:0] mem_addr;

    logic        bo_gnt, bo_rvalid, bo_mem_en, bo_mem_we, bo_vid_valid;
    logic [7:0]  bo_rdata, bo_mem_wdata, bo_vid_data, bo_frame_cnt;
    logic [12:0] bo_mem_addr;
    logic [7:0]  bo_mem_rdata;

    logic [7:0]  mem [0:8191];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_mem_arbiter u_dut (
        .clk(clk), .rst_n(rst_n), .display_on(display_on), .hpos(hpos), .vpos(vpos),
        .vsync(vsync), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .vid_data(vid_data),
        .vid_valid(vid_valid), .frame_cnt(frame_cnt)
    );

    vga_mem_arbiter #(.BLANK_ONLY(1)) u_dut_bo (
        .clk(clk), .rst_n(rst_n), .display_on(display_on), .hpos(hpos), .vpos(vpos),
        .vsync(vsync), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(bo_gnt), .host_rvalid(bo_rvalid),
        .host_rdata(bo_rdata), .mem_en(bo_mem_en), .mem_we(bo_mem_we), .mem_addr(bo_mem_addr),
        .mem_wdata(bo_mem_wdata), .mem_rdata(bo_mem_rdata), .vid_data(bo_vid_data),
        .vid_valid(bo_vid_valid), .frame_cnt(bo_frame_cnt)
    );

    // Memory model: writes at the clock edge, read data presented for capture at the next edge.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata    = mem[mem_addr];
    assign bo_mem_rdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".gnt"},    32'(host_gnt),    32'd0);
        chk({tag, ".rvalid"}, 32'(host_rvalid), 32'd0);
        chk({tag, ".rdata"},  32'(host_rdata),  32'd0);
        chk({tag, ".mem_en"}, 32'(mem_en),      32'd0);
        chk({tag, ".mem_we"}, 32'(mem_we),      32'd0);
        chk({tag, ".addr"},   32'(mem_addr),    32'd0);
        chk({tag, ".wdata"},  32'(mem_wdata),   32'd0);
        chk({tag, ".vdata"},  32'(vid_data),    32'd0);
        chk({tag, ".vvalid"}, 32'(vid_valid),   32'd0);
        chk({tag, ".frames"}, 32'(frame_cnt),   32'd0);
    endtask

    task automatic host_write(input logic [12:0] a, input logic [7:0] d);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        chk("wr.gnt", 32'(host_gnt), 32'd1);
        chk("wr.we",  32'(mem_we),   32'd1);
        host_req = 1'b0; host_we = 1'b0;
        tick();
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1; tick();
        vsync = 1'b0; tick();
    endtask

    initial begin
        int gnt_cnt;
        int vv_cnt;

        // Reset state
        tick(); tick();
        chk_reset_state("rst0");
        rst_n = 1'b1;
        tick();

        // Blanking write 0xA5 to 0x005, then read it back
        host_req = 1'b1; host_we = 1'b1; host_addr = 13'h005; host_wdata = 8'hA5;
        tick();
        chk("w5.gnt",   32'(host_gnt),  32'd1);
        chk("w5.en",    32'(mem_en),    32'd1);
        chk("w5.we",    32'(mem_we),    32'd1);
        chk("w5.addr",  32'(mem_addr),  32'h005);
        chk("w5.wdata", 32'(mem_wdata), 32'hA5);
        host_req = 1'b0; host_we = 1'b0;
        tick();
        chk("w5.gnt_off", 32'(host_gnt),    32'd0);
        chk("w5.en_off",  32'(mem_en),      32'd0);
        chk("w5.norv",    32'(host_rvalid), 32'd0);
        host_req = 1'b1;
        tick();
        chk("r5.gnt",  32'(host_gnt), 32'd1);
        chk("r5.en",   32'(mem_en),   32'd1);
        chk("r5.we",   32'(mem_we),   32'd0);
        chk("r5.addr", 32'(mem_addr), 32'h005);
        host_req = 1'b0;
        tick();
        chk("r5.rvalid", 32'(host_rvalid), 32'd1);
        chk("r5.rdata",  32'(host_rdata),  32'hA5);
        chk("r5.gnt_off", 32'(host_gnt),   32'd0);
        tick();
        chk("r5.rv_off", 32'(host_rvalid), 32'd0);
        chk("r5.hold",   32'(host_rdata),  32'hA5);

        // Preload cell 82 for the video fetch
        host_write(13'd82, 8'h5B);

        // Video slot at hpos=16 vpos=8 beats a pending host read
        display_on = 1'b1; hpos = 10'd16; vpos = 10'd8;
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h005;
        tick();
        chk("vs.gnt",  32'(host_gnt), 32'd0);
        chk("vs.en",   32'(mem_en),   32'd1);
        chk("vs.we",   32'(mem_we),   32'd0);
        chk("vs.addr", 32'(mem_addr), 32'd82);
        hpos = 10'd17;
        tick();
        chk("vs.gnt2",   32'(host_gnt),  32'd1);
        chk("vs.vvalid", 32'(vid_valid), 32'd1);
        chk("vs.vdata",  32'(vid_data),  32'h5B);
        chk("vs.haddr",  32'(mem_addr),  32'h005);
        chk("bo.active_gnt", 32'(bo_gnt), 32'd0);
        host_req = 1'b0;
        tick();
        chk("vs.rvalid",  32'(host_rvalid), 32'd1);
        chk("vs.rdata",   32'(host_rdata),  32'hA5);
        chk("vs.vv_off",  32'(vid_valid),   32'd0);
        chk("vs.vhold",   32'(vid_data),    32'h5B);

        // BLANK_ONLY: no grant while active, grant in the first blank cycle
        host_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hpos = 10'(18 + i);
            tick();
            chk("bo.wait", 32'(bo_gnt), 32'd0);
        end
        display_on = 1'b0;
        tick();
        chk("bo.gnt",  32'(bo_gnt),   32'd1);
        chk("bo.main", 32'(host_gnt), 32'd1);
        host_req = 1'b0;
        tick(); tick();

        // Full active line with host read held
        vpos = 10'd16; host_req = 1'b1; host_we = 1'b0; host_addr = 13'h010;
        gnt_cnt = 0; vv_cnt = 0;
        for (int h = 0; h < 640; h++) begin
            display_on = 1'b1; hpos = 10'(h);
            tick();
            chk("line.gnt", 32'(host_gnt), 32'(h[2:0] != 3'd0));
            if (h[2:0] == 3'd0) chk("line.addr", 32'(mem_addr), 32'(160 + (h >> 3)));
            if (host_gnt) gnt_cnt++;
            if (vid_valid) vv_cnt++;
        end
        display_on = 1'b0; host_req = 1'b0;
        tick(); tick();
        chk("line.grants", 32'(gnt_cnt), 32'd560);
        chk("line.vvalid", 32'(vv_cnt),  32'd80);

        // Frame counter: pulses, held-high vsync, wrap
        for (int i = 0; i < 3; i++) vsync_pulse();
        chk("fc.three", 32'(frame_cnt), 32'd3);
        vsync = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        vsync = 1'b0; tick();
        chk("fc.held", 32'(frame_cnt), 32'd4);
        for (int i = 0; i < 252; i++) vsync_pulse();
        chk("fc.wrap", 32'(frame_cnt), 32'd0);
        vsync_pulse();
        chk("fc.one", 32'(frame_cnt), 32'd1);

        // Reset right after a host read grant drops the read
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h005;
        tick();
        chk("rr.gnt", 32'(host_gnt), 32'd1);
        rst_n = 1'b0; host_req = 1'b0;
        tick();
        chk_reset_state("rst1");
        // Grant possible in the first cycle after release
        rst_n = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 13'h007; host_wdata = 8'hC3;
        tick();
        chk("rel.gnt",    32'(host_gnt),    32'd1);
        chk("rel.addr",   32'(mem_addr),    32'h007);
        chk("rel.rvalid", 32'(host_rvalid), 32'd0);
        host_req = 1'b0; host_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rel.no_rv", 32'(host_rvalid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, memory address width (80x60 cells).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter BLANK_ONLY, default 0; 1 = host granted only while display_on=0.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port display_on  input  1  VGA active-video flag from timing generator.
REQ-007 SHALL have ports hpos, vpos  input  10 each  current pixel position.
REQ-008 SHALL have port vsync  input  1  VGA vertical sync, active-high pulse.
REQ-009 SHALL have ports host_req, host_we  input  1 each  host access request and write flag.
REQ-010 SHALL have ports host_addr, host_wdata  input  ADDR_W / DATA_W  host address and write data.
REQ-011 SHALL have ports host_gnt, host_rvalid  output  1 each  access accepted; read data valid.
REQ-012 SHALL have port host_rdata  output  DATA_W  host read data.
REQ-013 SHALL have ports mem_en, mem_we  output  1 each  single-port memory strobe and write enable.
REQ-014 SHALL have ports mem_addr, mem_wdata  output  ADDR_W / DATA_W  memory address and write data.
REQ-015 SHALL have port mem_rdata  input  DATA_W  memory read data, 1-cycle latency after mem_en.
REQ-016 SHALL have ports vid_data, vid_valid  output  DATA_W / 1  fetched cell byte and its strobe.
REQ-017 SHALL have port frame_cnt  output  8  frames completed.

Function
REQ-018 Video slot SHALL be a cycle with display_on=1 and hpos[2:0]=0.
REQ-019 In a video slot SHALL drive mem_en=1, mem_we=0, mem_addr={vpos[8:3]*80 + hpos[9:3]} truncated to ADDR_W, registered outputs.
REQ-020 Video SHALL have absolute priority; video slot with host_req=1 -> host_gnt=0 that cycle.
REQ-021 Outside a video slot, host_req=1 (and display_on=0 when BLANK_ONLY=1) SHALL produce host_gnt=1 for exactly one cycle and one memory access with host_addr/host_we/host_wdata.
REQ-022 Host SHALL hold req/addr/we/wdata stable until host_gnt; deasserting req before grant abandons the request with no access.
REQ-023 Back-to-back grants SHALL be allowed; a continuously asserted host_req receives a grant every non-video cycle.
REQ-024 State machine IDLE / VID_RD / HOST_RD: IDLE->VID_RD on video slot; IDLE->HOST_RD on granted host read; granted write stays IDLE; VID_RD/HOST_RD return to IDLE next cycle (or to a new VID_RD/HOST_RD if one is issued the same cycle).
REQ-025 VID_RD SHALL register mem_rdata into vid_data and pulse vid_valid for one cycle, 1 cycle after the slot.
REQ-026 HOST_RD SHALL register mem_rdata into host_rdata and pulse host_rvalid for one cycle, 1 cycle after host_gnt; host writes never assert host_rvalid.
REQ-027 vid_data and host_rdata SHALL hold their last value between strobes.
REQ-028 frame_cnt SHALL increment by 1 on each vsync rising edge (registered edge detect), wrapping 255->0.
REQ-029 mem_en=0 in any cycle with neither a video slot nor a grant; mem_we=1 only on granted host writes.

Reset
REQ-030 While rst_n=0 at a clock edge: state IDLE; host_gnt, host_rvalid, vid_valid, mem_en, mem_we=0; host_rdata, vid_data, mem_addr, mem_wdata=0; frame_cnt=0; vsync edge register=0.
REQ-031 Reset during VID_RD/HOST_RD SHALL drop the outstanding read: no vid_valid/host_rvalid after reset release.
REQ-032 First video slot or grant SHALL be possible in the first cycle after rst_n returns high.

Verification
REQ-033 Blanking, host write addr 0x005 data 0xA5 -> host_gnt and mem_en/mem_we=1, addr 0x005 same cycle; later host read addr 0x005 -> host_rvalid with 0xA5 one cycle after gnt.
REQ-034 display_on=1, hpos=16, vpos=8, host_req=1 -> host_gnt=0, mem_addr=82; next cycle host_gnt=1 and vid_valid=1 with stored byte.
REQ-035 Full active line, host_req held: grants in exactly 7 of every 8 cycles, vid_valid 80 times per line.
REQ-036 BLANK_ONLY=1, display_on=1, host_req=1 -> no grant until display_on=0, then grant that cycle.
REQ-037 rst_n low in cycle after host read grant -> host_rvalid never asserts; all outputs at reset values.
REQ-038 256 vsync pulses -> frame_cnt returns to 0; held-high vsync counts once.
